// File: rtl/lsq_alloc_ctrl.sv
// LSQ slot allocation controller: grants slot IDs from an external free-ID
// queue and tracks each slot through FREE/ALLOC/DONE. Slots retire in
// dispatch order through a small age FIFO, and their IDs go back to the queue.
module lsq_alloc_ctrl #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ORD_DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Rest,
    input  logic            DispValid,
    output logic            DispReady,
    output logic [ID_W-1:0] DispId,
    input  logic            CmplValid,
    input  logic [ID_W-1:0] CmplId,
    input  logic            CommitEn,
    input  logic            Flush,
    input  logic [ID_W-1:0] FreePreOut,
    input  logic            FreeEmpty,
    output logic            FreeRable,
    output logic            FreeWable,
    output logic [ID_W-1:0] FreeDin,
    output logic            FreeClean,
    output logic            RetireValid,
    output logic [ID_W-1:0] RetireId,
    output logic [2:0]      InFlight,
    output logic            CmplErr
);

    localparam int unsigned N_SLOTS   = 2 ** ID_W;
    localparam int unsigned PTR_W     = $clog2(ORD_DEPTH);
    localparam logic [3:0]  DEPTH_CNT = 4'(ORD_DEPTH);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_DONE  = 2'd2
    } slot_state_e;

    slot_state_e            slot_st [N_SLOTS];
    logic [ID_W-1:0]        ord_mem [ORD_DEPTH];
    logic [PTR_W-1:0]       head_ptr;
    logic [PTR_W-1:0]       tail_ptr;
    logic [ID_W-1:0]        head_id;
    logic                   fire;
    logic                   retire;
    logic                   cmpl_hit;

    // Grant, retire and completion decode from the current registered state
    always_comb begin
        head_id   = ord_mem[head_ptr];
        DispReady = !FreeEmpty && !Flush && ({1'b0, InFlight} < DEPTH_CNT);
        fire      = DispValid && DispReady;
        FreeRable = fire;
        DispId    = FreePreOut;
        retire    = (InFlight != 3'd0) && (slot_st[head_id] == ST_DONE)
                    && CommitEn && !Flush;
        cmpl_hit  = CmplValid && (slot_st[CmplId] == ST_ALLOC);
    end

    // Per-slot state table; the three updates never target the same slot
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            slot_st <= '{default: ST_FREE};
        end else if (Flush) begin
            slot_st <= '{default: ST_FREE};
        end else begin
            if (cmpl_hit) slot_st[CmplId]  <= ST_DONE;
            if (retire)   slot_st[head_id] <= ST_FREE;
            if (fire)     slot_st[DispId]  <= ST_ALLOC;
        end
    end

    // Age FIFO holding slot IDs in dispatch order; pointers wrap naturally
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            ord_mem  <= '{default: '0};
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (Flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (fire) begin
                ord_mem[tail_ptr] <= DispId;
                tail_ptr          <= tail_ptr + PTR_W'(1);
            end
            if (retire) head_ptr <= head_ptr + PTR_W'(1);
        end
    end

    // Occupancy count; fire and retire together cancel out
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            InFlight <= 3'd0;
        end else if (Flush) begin
            InFlight <= 3'd0;
        end else if (fire && !retire) begin
            InFlight <= InFlight + 3'd1;
        end else if (retire && !fire) begin
            InFlight <= InFlight - 3'd1;
        end
    end

    // Registered pulses toward the free-ID queue, the ROB and error reporting
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            FreeWable   <= 1'b0;
            FreeDin     <= '0;
            RetireValid <= 1'b0;
            RetireId    <= '0;
            CmplErr     <= 1'b0;
            FreeClean   <= 1'b0;
        end else begin
            FreeClean   <= Flush;
            FreeWable   <= retire;
            RetireValid <= retire;
            CmplErr     <= CmplValid && !cmpl_hit && !Flush;
            if (retire) begin
                FreeDin  <= head_id;
                RetireId <= head_id;
            end
        end
    end

endmodule
